// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity modes and baud helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period down-counter, tick on the last cycle of each bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero while idle so a fresh accept always starts a full bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = RELOAD;
    end else if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter with valid/ready input
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 12_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TX_DV,
  input  logic [DATA_BITS-1:0] TX_BYTE,
  output logic                 TX_READY,
  output logic                 TX_DATA,
  output logic                 BUSY
);

  localparam int         CPB       = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (CPB < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_cfg: CLK_HZ/BAUD must be at least 2");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 parity_q, parity_d;
  logic [3:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 tick, last_stop, accept;

  uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk     (CLK),
    .rst     (RST),
    .run     (state_q != ST_IDLE),
    .restart (accept),
    .tick    (tick)
  );

  assign last_stop = (state_q == ST_STOP) && tick && (idx_q == LAST_STOP);
  assign TX_READY  = (state_q == ST_IDLE) || last_stop;
  assign accept    = TX_DV && TX_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    idx_d    = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_START;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (idx_q == LAST_STOP) begin
            idx_d   = '0;
            state_d = accept ? ST_START : ST_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    // Word and its parity are frozen at the accepting edge.
    if (accept) begin
      shreg_d  = TX_BYTE;
      parity_d = (PARITY == PAR_EVEN) ? ^TX_BYTE : ~^TX_BYTE;
    end
  end

  // Outputs derive from the next state so the pin is a plain flop.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      ST_IDLE:   busy_d = 1'b0;
      ST_START:  tx_d   = 1'b0;
      ST_DATA:   tx_d   = shreg_d[0];
      ST_PARITY: tx_d   = parity_q;
      ST_STOP:   tx_d   = 1'b1;
      default:   busy_d = 1'b0;
    endcase
  end

  assign TX_DATA = tx_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed bench for uart_tx_cfg in 8N1, 8E1 and 7O2 configurations
module tb_uart_tx_cfg;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [7:0] byte_in;
  int         sel;

  logic rdy_a, tx_a, busy_a;
  logic rdy_b, tx_b, busy_b;
  logic rdy_c, tx_c, busy_c;
  logic tx_m, busy_m, rdy_m;

  int vectors = 0;
  int errors  = 0;

  logic tx_s[$];
  logic busy_s[$];
  logic rdy_s[$];
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_HZ(12_000_000), .BAUD(3_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .CLK(clk), .RST(rst), .TX_DV(dv && sel == 0), .TX_BYTE(byte_in),
    .TX_READY(rdy_a), .TX_DATA(tx_a), .BUSY(busy_a)
  );

  uart_tx_cfg #(.CLK_HZ(12_000_000), .BAUD(3_000_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .CLK(clk), .RST(rst), .TX_DV(dv && sel == 1), .TX_BYTE(byte_in),
    .TX_READY(rdy_b), .TX_DATA(tx_b), .BUSY(busy_b)
  );

  uart_tx_cfg #(.CLK_HZ(12_000_000), .BAUD(3_000_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .CLK(clk), .RST(rst), .TX_DV(dv && sel == 2), .TX_BYTE(byte_in[6:0]),
    .TX_READY(rdy_c), .TX_DATA(tx_c), .BUSY(busy_c)
  );

  always_comb begin
    tx_m   = (sel == 0) ? tx_a   : (sel == 1) ? tx_b   : tx_c;
    busy_m = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    rdy_m  = (sel == 0) ? rdy_a  : (sel == 1) ? rdy_b  : rdy_c;
  end

  // Expected line level per clock: each character is one bit period.
  function automatic void set_exp(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++)
      repeat (CPB) exp_q.push_back(s[i] == "1");
  endfunction

  task automatic capture(input int n, input int drop_at, input bit noise);
    tx_s.delete(); busy_s.delete(); rdy_s.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_s.push_back(tx_m);
      busy_s.push_back(busy_m);
      rdy_s.push_back(rdy_m);
      if (noise && i >= 5 && i < 30) begin
        byte_in = ~byte_in;
        dv      = i[1];
      end else if (noise && i == 30) begin
        dv = 1'b0;
      end
      if (i == drop_at) dv = 1'b0;
    end
  endtask

  task automatic start_frame(input logic [7:0] b);
    @(negedge clk);
    vectors++;
    if (rdy_m !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_accept sel=%0d got=%b want=1", sel, rdy_m);
    end
    byte_in = b;
    dv      = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; dv = 1'b0; byte_in = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      vectors++;
      if (tx_m !== 1'b1 || busy_m !== 1'b0 || rdy_m !== 1'b1) begin
        errors++;
        $display("FAIL reset_state sel=%0d tx/busy/rdy=%b%b%b want=101", s, tx_m, busy_m, rdy_m);
      end
    end
  endtask

  task automatic test_8n1_a5;
    sel = 0;
    start_frame(8'hA5);
    capture(41, -1, 1'b0);
    set_exp("0101001011");
    for (int k = 0; k < 40; k++) begin
      vectors++;
      if (tx_s[k] !== exp_q[k] || busy_s[k] !== 1'b1 || rdy_s[k] !== (k == 39)) begin
        errors++;
        $display("FAIL a5_8n1 k=%0d tx/busy/rdy=%b%b%b want=%b1%b", k, tx_s[k], busy_s[k], rdy_s[k], exp_q[k], k == 39);
      end
    end
    vectors++;
    if (tx_s[40] !== 1'b1 || busy_s[40] !== 1'b0 || rdy_s[40] !== 1'b1) begin
      errors++;
      $display("FAIL a5_8n1_end tx/busy/rdy=%b%b%b want=101", tx_s[40], busy_s[40], rdy_s[40]);
    end
  endtask

  task automatic test_8e1_07;
    sel = 1;
    start_frame(8'h07);
    capture(45, -1, 1'b0);
    set_exp("01110000011");
    for (int k = 0; k < 44; k++) begin
      vectors++;
      if (tx_s[k] !== exp_q[k] || busy_s[k] !== 1'b1 || rdy_s[k] !== (k == 43)) begin
        errors++;
        $display("FAIL 07_8e1 k=%0d tx/busy/rdy=%b%b%b want=%b1%b", k, tx_s[k], busy_s[k], rdy_s[k], exp_q[k], k == 43);
      end
    end
    vectors++;
    if (tx_s[44] !== 1'b1 || busy_s[44] !== 1'b0) begin
      errors++;
      $display("FAIL 07_8e1_end tx/busy=%b%b want=10", tx_s[44], busy_s[44]);
    end
  endtask

  task automatic test_7o2_55;
    sel = 2;
    start_frame(8'h55);
    capture(45, -1, 1'b0);
    set_exp("01010101111");
    for (int k = 0; k < 44; k++) begin
      vectors++;
      if (tx_s[k] !== exp_q[k] || busy_s[k] !== 1'b1 || rdy_s[k] !== (k == 43)) begin
        errors++;
        $display("FAIL 55_7o2 k=%0d tx/busy/rdy=%b%b%b want=%b1%b", k, tx_s[k], busy_s[k], rdy_s[k], exp_q[k], k == 43);
      end
    end
    vectors++;
    if (tx_s[44] !== 1'b1 || busy_s[44] !== 1'b0) begin
      errors++;
      $display("FAIL 55_7o2_end tx/busy=%b%b want=10", tx_s[44], busy_s[44]);
    end
  endtask

  task automatic test_back_to_back;
    sel = 0;
    @(negedge clk);
    byte_in = 8'h00;
    dv      = 1'b1;
    @(posedge clk);
    #1 byte_in = 8'hFF;
    capture(81, 40, 1'b0);
    set_exp("00000000010111111111");
    for (int k = 0; k < 80; k++) begin
      vectors++;
      if (tx_s[k] !== exp_q[k] || busy_s[k] !== 1'b1 || rdy_s[k] !== (k == 39 || k == 79)) begin
        errors++;
        $display("FAIL b2b k=%0d tx/busy/rdy=%b%b%b want=%b1%b", k, tx_s[k], busy_s[k], rdy_s[k], exp_q[k], k == 39 || k == 79);
      end
    end
    vectors++;
    if (tx_s[80] !== 1'b1 || busy_s[80] !== 1'b0 || rdy_s[80] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end tx/busy/rdy=%b%b%b want=101", tx_s[80], busy_s[80], rdy_s[80]);
    end
  endtask

  task automatic test_reset_mid_frame;
    sel = 0;
    start_frame(8'hA5);
    capture(18, -1, 1'b0);
    set_exp("0101001011");
    for (int k = 0; k < 18; k++) begin
      vectors++;
      if (tx_s[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL pre_reset k=%0d tx=%b want=%b", k, tx_s[k], exp_q[k]);
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx_m !== 1'b1 || busy_m !== 1'b0 || rdy_m !== 1'b1) begin
      errors++;
      $display("FAIL abort tx/busy/rdy=%b%b%b want=101", tx_m, busy_m, rdy_m);
    end
    start_frame(8'h3C);
    capture(41, -1, 1'b0);
    set_exp("0001111001");
    for (int k = 0; k < 40; k++) begin
      vectors++;
      if (tx_s[k] !== exp_q[k] || busy_s[k] !== 1'b1) begin
        errors++;
        $display("FAIL 3c_after_reset k=%0d tx/busy=%b%b want=%b1", k, tx_s[k], busy_s[k], exp_q[k]);
      end
    end
    vectors++;
    if (tx_s[40] !== 1'b1 || busy_s[40] !== 1'b0) begin
      errors++;
      $display("FAIL 3c_end tx/busy=%b%b want=10", tx_s[40], busy_s[40]);
    end
  endtask

  task automatic test_ignore_mid_frame;
    sel = 0;
    start_frame(8'hA5);
    capture(48, -1, 1'b1);
    set_exp("0101001011");
    for (int k = 0; k < 40; k++) begin
      vectors++;
      if (tx_s[k] !== exp_q[k] || busy_s[k] !== 1'b1) begin
        errors++;
        $display("FAIL ignore k=%0d tx/busy=%b%b want=%b1", k, tx_s[k], busy_s[k], exp_q[k]);
      end
    end
    for (int k = 40; k < 48; k++) begin
      vectors++;
      if (tx_s[k] !== 1'b1 || busy_s[k] !== 1'b0) begin
        errors++;
        $display("FAIL ignore_no_second k=%0d tx/busy=%b%b want=10", k, tx_s[k], busy_s[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1_a5();
    test_8e1_07();
    test_7o2_55();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignore_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
